// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative read-only instruction cache
//
// Purpose: CPU-side fetch port backed by a line-wide memory port. Each set
// holds NUM_WAYS lines with one valid bit per way and a tree pseudo-LRU word.
// A hit responds one cycle after acceptance. A miss fetches the line, writes
// it into the victim way, and then responds. Refills go to the lowest invalid
// way first, and to the PLRU victim otherwise.
//
// Optional feature: define ICACHE_PREFETCH_EN to add a one-line next-line
// prefetch buffer that is filled after every demand refill.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   mem_address  CPU word address, held while mem_read is high
//   mem_read     CPU fetch request
//   mem_rdata    fetched word, valid with mem_resp
//   mem_resp     one-cycle completion pulse
//   pmem_address line-aligned memory address
//   pmem_read    line read request, held until pmem_resp
//   pmem_rdata   returned line
//   pmem_resp    memory completion pulse
module icache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 mem_address,
  input  logic                        mem_read,
  output logic [31:0]                 mem_rdata,
  output logic                        mem_resp,
  output logic [31:0]                 pmem_address,
  output logic                        pmem_read,
  input  logic [8*(2**s_offset)-1:0]  pmem_rdata,
  input  logic                        pmem_resp
);
  localparam int LINE_W   = 8 * (2**s_offset);
  localparam int NUM_SETS = 2**s_index;
  localparam int TAG_W    = 32 - s_offset - s_index;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int WORD_W   = s_offset - 2;

`ifdef ICACHE_PREFETCH_EN
  localparam int LADDR_W  = 32 - s_offset;
  typedef enum logic [1:0] {IDLE, FETCH, PREFETCH} state_t;
`else
  typedef enum logic {IDLE, FETCH} state_t;
`endif

  state_t              state_q;
  logic                mem_resp_q;
  logic [31:0]         mem_rdata_q;
  logic                pmem_read_q;
  logic [31:0]         pmem_address_q;
  logic [TAG_W-1:0]    fetch_tag_q;
  logic [s_index-1:0]  fetch_idx_q;
  logic [WORD_W-1:0]   fetch_word_q;
  logic                dropped_q;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]    req_tag;
  logic [s_index-1:0]  req_idx;
  logic [WORD_W-1:0]   req_word;
  logic                unused_addr_bits;

  assign req_tag          = mem_address[31 -: TAG_W];
  assign req_idx          = mem_address[s_offset +: s_index];
  assign req_word         = mem_address[s_offset-1:2];
  assign unused_addr_bits = ^mem_address[1:0];

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = pmem_address_q;

  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line,
                                          input logic [WORD_W-1:0] w);
    logic [LINE_W-1:0] sh;
    sh = line >> {w, 5'd0};
    return sh[31:0];
  endfunction

  // Heap-ordered tree: node n has children 2n+1 / 2n+2. A bit of 0 points
  // the victim walk to the left child, 1 to the right child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [NUM_WAYS-2:0] sh;
    int node;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = bits >> node;
      node = 2 * node + 1 + int'(sh[0]);
    end
    return WAY_W'(node - (NUM_WAYS - 1));
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [NUM_WAYS-2:0] res;
    logic [NUM_WAYS-2:0] mask;
    logic [WAY_W-1:0]    way_sh;
    logic                dir;
    int                  node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      way_sh  = way >> (WAY_W - 1 - l);
      dir     = way_sh[0];
      mask    = '0;
      mask[0] = 1'b1;
      mask    = mask << node;
      res     = dir ? (res & ~mask) : (res | mask);
      node    = 2 * node + 1 + int'(dir);
    end
    return res;
  endfunction

  // Demand lookup
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             accept;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // A request is not accepted in the cycle its previous response is shown,
  // because the CPU still holds the old address during that cycle.
  assign accept = (state_q == IDLE) && mem_read && !mem_resp_q;

`ifdef ICACHE_PREFETCH_EN
  logic               pf_valid_q;
  logic [LADDR_W-1:0] pf_line_q;
  logic [LINE_W-1:0]  pf_data_q;
  logic               pf_take;
  logic [LADDR_W-1:0] next_line;
  logic               next_cached;

  assign pf_take   = accept && !hit && pf_valid_q && (pf_line_q == mem_address[31:s_offset]);
  assign next_line = {fetch_tag_q, fetch_idx_q} + LADDR_W'(1);

  always_comb begin
    next_cached = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[next_line[s_index-1:0]][w] &&
          tag_mem[next_line[s_index-1:0]][w] == next_line[LADDR_W-1:s_index]) begin
        next_cached = 1'b1;
      end
    end
  end
`endif

  // Line write port: a demand refill, or promotion of the prefetch buffer
  logic                wr_en;
  logic [s_index-1:0]  wr_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic [LINE_W-1:0]   wr_line;
  logic [WAY_W-1:0]    victim;
  logic                found_invalid;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = fetch_idx_q;
    wr_tag  = fetch_tag_q;
    wr_line = pmem_rdata;
    if (state_q == FETCH && pmem_resp) begin
      wr_en = 1'b1;
    end
`ifdef ICACHE_PREFETCH_EN
    else if (pf_take) begin
      wr_en   = 1'b1;
      wr_idx  = req_idx;
      wr_tag  = req_tag;
      wr_line = pf_data_q;
    end
`endif
  end

  always_comb begin
    victim        = plru_victim(plru_q[wr_idx]);
    found_invalid = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_invalid && !valid_q[wr_idx][w]) begin
        found_invalid = 1'b1;
        victim        = WAY_W'(w);
      end
    end
  end

  // Tags and data need no reset: they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx][victim]  <= wr_tag;
      data_mem[wr_idx][victim] <= wr_line;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_address_q <= '0;
      fetch_tag_q    <= '0;
      fetch_idx_q    <= '0;
      fetch_word_q   <= '0;
      dropped_q      <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
`ifdef ICACHE_PREFETCH_EN
      pf_valid_q <= 1'b0;
      pf_line_q  <= '0;
      pf_data_q  <= '0;
`endif
    end else begin
      mem_resp_q <= 1'b0;
      if (wr_en) begin
        valid_q[wr_idx][victim] <= 1'b1;
        plru_q[wr_idx]          <= plru_touch(plru_q[wr_idx], victim);
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              mem_resp_q      <= 1'b1;
              mem_rdata_q     <= word_of(data_mem[req_idx][hit_way], req_word);
              plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            end
`ifdef ICACHE_PREFETCH_EN
            else if (pf_take) begin
              mem_resp_q  <= 1'b1;
              mem_rdata_q <= word_of(pf_data_q, req_word);
              pf_valid_q  <= 1'b0;
            end
`endif
            else begin
              state_q        <= FETCH;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_tag, req_idx, {s_offset{1'b0}}};
              fetch_tag_q    <= req_tag;
              fetch_idx_q    <= req_idx;
              fetch_word_q   <= req_word;
              dropped_q      <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (!mem_read) dropped_q <= 1'b1;
          if (pmem_resp) begin
            pmem_read_q <= 1'b0;
            state_q     <= IDLE;
            // A CPU that let go of mem_read during the refill gets no response.
            if (mem_read && !dropped_q) begin
              mem_resp_q  <= 1'b1;
              mem_rdata_q <= word_of(pmem_rdata, fetch_word_q);
            end
`ifdef ICACHE_PREFETCH_EN
            if (!next_cached) begin
              state_q        <= PREFETCH;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {next_line, {s_offset{1'b0}}};
            end
`endif
          end
        end
`ifdef ICACHE_PREFETCH_EN
        PREFETCH: begin
          // Demand requests wait here and are looked up again from IDLE.
          if (pmem_resp) begin
            pmem_read_q <= 1'b0;
            state_q     <= IDLE;
            pf_valid_q  <= 1'b1;
            pf_line_q   <= pmem_address_q[31:s_offset];
            pf_data_q   <= pmem_rdata;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - scoreboard bench for icache_nway with a tag/recency reference model
module tb_icache_nway;
  localparam int OFF  = 5;
  localparam int IDX  = 3;
  localparam int WAYS = 4;
  localparam int SETS = 8;
  localparam int LW   = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic [31:0]   mem_rdata;
  logic          mem_resp;
  logic [31:0]   pmem_address;
  logic          pmem_read;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  icache_nway #(.s_offset(OFF), .s_index(IDX), .NUM_WAYS(WAYS)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit inject_idle_resp = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    int          issue_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fetch_q[$];

  // Reference model: per-way tag, valid and last-access time
  bit          m_valid [SETS][WAYS];
  logic [23:0] m_tag   [SETS][WAYS];
  int unsigned m_stamp [SETS][WAYS];
  int unsigned m_time;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [31:0] line_word(input logic [26:0] line, input int w);
    return (32'(line) * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^ 32'h0BADF00D;
  endfunction

  function automatic void model_reset();
    m_time = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_stamp[s][w] = 0;
      end
  endfunction

  // Tree PLRU victim: in each half-split, descend into the half that does
  // not contain the most recently used way.
  function automatic int plru_pick(input int s);
    int lo, size, half;
    int unsigned ml, mr;
    lo = 0;
    size = WAYS;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int w = 0; w < half; w++) begin
        if (m_stamp[s][lo + w] > ml) ml = m_stamp[s][lo + w];
        if (m_stamp[s][lo + half + w] > mr) mr = m_stamp[s][lo + half + w];
      end
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  // Returns 1 on a miss. Installs the line either way.
  function automatic bit model_access(input logic [31:0] a);
    int s, v;
    logic [23:0] t;
    bit found;
    s = int'(a[7:5]);
    t = a[31:8];
    m_time++;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!found && m_valid[s][w] && m_tag[s][w] == t) begin
        found = 1'b1;
        m_stamp[s][w] = m_time;
      end
    if (!found) begin
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = plru_pick(s);
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_stamp[s][v] = m_time;
    end
    return !found;
  endfunction

  task automatic do_read(input logic [31:0] a);
    exp_t e;
    int n;
    e.addr      = a;
    e.data      = line_word(a[31:5], int'(a[4:2]));
    e.miss      = model_access(a);
    e.issue_cyc = cyc;
    exp_q.push_back(e);
    if (e.miss) fetch_q.push_back({a[31:5], 5'd0});
    mem_address = a;
    mem_read    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_resp && n < 100);
    if (!mem_resp) begin
      n_checks++;
      $display("FAIL resp_timeout addr=%h: no mem_resp in %0d cycles, required one", a, n);
    end
    mem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_pmem_read(input string name);
    int n;
    n = 0;
    while (!pmem_read && n < 50) begin @(negedge clk); n++; end
    if (!pmem_read) begin
      n_checks++;
      $display("FAIL %s: pmem_read got 0 required 1", name);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  // Memory responder
  initial begin
    int lat;
    int dly;
    lat = 0;
    dly = 1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (inject_idle_resp && !pmem_read) begin
        pmem_rdata = {8{32'hDEADBEEF}};
        pmem_resp  = 1'b1;
      end else if (!rst || !pmem_read) begin
        lat = 0;
      end else begin
        lat++;
        if (lat >= dly) begin
          for (int w = 0; w < 8; w++) pmem_rdata[w*32 +: 32] = line_word(pmem_address[31:5], w);
          pmem_resp = 1'b1;
          lat = 0;
          dly = $urandom_range(1, 4);
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t        e;
    logic [31:0] fa;
    bit          prev_pread;
    prev_pread = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_pread = 1'b0;
      end else begin
        if (pmem_read && !prev_pread) begin
          if (fetch_q.size() == 0) begin
            n_checks++;
            $display("FAIL pmem_read_unexpected: got request to %h required none", pmem_address);
          end else begin
            fa = fetch_q.pop_front();
            check("pmem_address", pmem_address, fa);
          end
        end
        prev_pread = pmem_read;
        if (mem_resp) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL mem_resp_spurious: got mem_resp rdata=%h required none", mem_rdata);
          end else begin
            e = exp_q.pop_front();
            check("mem_rdata", mem_rdata, e.data);
            check("fetches_before_resp", 32'(fetch_q.size()), 32'd0);
            if (!e.miss) check("hit_latency", 32'(cyc - e.issue_cyc), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit          dm;
    rst          = 1'b0;
    mem_read     = 1'b0;
    mem_address  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_mem_resp", 32'(mem_resp), 32'd0);
    check("reset_pmem_read", 32'(pmem_read), 32'd0);
    check("reset_pmem_address", pmem_address, 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then hit on the same line
    do_read(32'h0000_0040);
    do_read(32'h0000_0044);

    // Fill all four ways of set 0, re-touch, then force a replacement
    do_read(32'h0000_0000);
    do_read(32'h0000_0100);
    do_read(32'h0000_0200);
    do_read(32'h0000_0300);
    do_read(32'h0000_0004);
    do_read(32'h0000_0400);
    do_read(32'h0000_0008);
    do_read(32'h0000_0104);
    do_read(32'h0000_0208);
    do_read(32'h0000_031C);

    // Memory response while idle must be ignored
    inject_idle_resp = 1'b1;
    repeat (2) @(negedge clk);
    inject_idle_resp = 1'b0;
    @(negedge clk);
    do_read(32'h0000_0048);
    do_read(32'h0000_0060);

    // CPU drops mem_read mid-refill: line is still filled, no response
    a  = 32'h0000_05E0;
    dm = model_access(a);
    if (dm) fetch_q.push_back({a[31:5], 5'd0});
    mem_address = a;
    mem_read    = 1'b1;
    @(negedge clk);
    wait_pmem_read("drop_fetch_start");
    mem_read = 1'b0;
    repeat (8) @(negedge clk);
    check("drop_fetch_done", 32'(pmem_read), 32'd0);
    do_read(32'h0000_05E4);

    // Reset while a refill is outstanding
    a  = 32'h0000_07A4;
    dm = model_access(a);
    if (dm) fetch_q.push_back({a[31:5], 5'd0});
    mem_address = a;
    mem_read    = 1'b1;
    @(negedge clk);
    wait_pmem_read("reset_fetch_start");
    rst = 1'b0;
    #1;
    check("midfetch_reset_pmem_read", 32'(pmem_read), 32'd0);
    check("midfetch_reset_pmem_address", pmem_address, 32'd0);
    check("midfetch_reset_mem_resp", 32'(mem_resp), 32'd0);
    check("midfetch_reset_mem_rdata", mem_rdata, 32'd0);
    mem_read = 1'b0;
    exp_q.delete();
    fetch_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(32'h0000_07A4);
    do_read(32'h0000_0040);

    // Randomized traffic over two sets and six tags to exercise eviction
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = (32'($urandom_range(0, 5)) << 8) |
          (($urandom_range(0, 1) == 0) ? 32'h0 : 32'hA0) |
          (32'($urandom_range(0, 7)) << 2);
      do_read(a);
    end

    repeat (5) @(negedge clk);
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);
    check("drain_fetch_q", 32'(fetch_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
